aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl.sv | 125 ++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule sequencer: steps 4 columns per round for NROUNDS rounds,
// stalls on missing randomness, and drives the round-constant unit strobes.
module aes_key_sched_ctrl #(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned NCOLS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_inverse,
  output logic       in_ready,
  input  logic       rnd_valid,
  input  logic       abort,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       col_en,
  output logic [1:0] col_idx,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic       rcon_init,
  output logic       rcon_update,
  output logic       rcon_mask,
  output logic       rcon_inverse
);

  localparam logic [1:0] LAST_COL   = 2'(NCOLS - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0] round_q, round_d;
  logic       inv_q, inv_d;

  logic in_idle, in_run, in_done;
  logic step, col_wrap, round_last;

  // Strobes are decoded from state and live inputs: the datapath and the
  // round-constant unit act on them in the same cycle they are requested.
  always_comb begin
    in_idle    = !rst && (state_q == IDLE);
    in_run     = !rst && (state_q == RUN);
    in_done    = !rst && (state_q == DONE);
    col_wrap   = (col_q == LAST_COL);
    round_last = (round_q == LAST_ROUND);
    step       = in_run && rnd_valid && !abort;

    in_ready     = in_idle;
    out_valid    = in_done;
    col_en       = step;
    rcon_mask    = step && (col_q == 2'd0);
    rcon_update  = step && col_wrap && !round_last;
    rcon_init    = in_idle && in_valid;
    last_round   = in_run && round_last;
    col_idx      = rst ? 2'd0 : col_q;
    round_idx    = rst ? 4'd0 : round_q;
    // In IDLE the direction comes straight from the request so the
    // init pulse loads the right constant before the latch takes effect.
    rcon_inverse = rst ? 1'b0 : ((state_q == IDLE) ? in_inverse : inv_q);
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    round_d = round_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          col_d   = 2'd0;
          round_d = 4'd0;
          inv_d   = in_inverse;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          col_d   = 2'd0;
          round_d = 4'd0;
        end else if (rnd_valid) begin
          col_d = col_q + 2'd1;
          if (col_wrap) begin
            if (round_last) state_d = DONE;
            else            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          col_d   = 2'd0;
          round_d = 4'd0;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only (synchronous), and state
  // updates use non-blocking assignments so all registers see the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      round_q <= 4'd0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      round_q <= round_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with an attached round-constant model
// and a queue of expected constants consumed at each rcon_mask pulse.
module tb_aes_key_sched_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_inverse;
  logic       in_ready;
  logic       rnd_valid;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic       col_en;
  logic [1:0] col_idx;
  logic [3:0] round_idx;
  logic       last_round;
  logic       rcon_init;
  logic       rcon_update;
  logic       rcon_mask;
  logic       rcon_inverse;

  aes_key_sched_ctrl #(.NROUNDS(10), .NCOLS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_inverse   (in_inverse),
    .in_ready     (in_ready),
    .rnd_valid    (rnd_valid),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .col_en       (col_en),
    .col_idx      (col_idx),
    .round_idx    (round_idx),
    .last_round   (last_round),
    .rcon_init    (rcon_init),
    .rcon_update  (rcon_update),
    .rcon_mask    (rcon_mask),
    .rcon_inverse (rcon_inverse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cyc       = 0;
  int start_cyc = -1;
  int first_ov  = -1;
  int n_mask    = 0;
  int n_upd     = 0;
  int n_last    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] fwd_tbl[10];
  logic [7:0] rc;

  // Round-constant unit driven only by the controller strobes.
  function automatic logic [7:0] rc_next(input logic [7:0] v, input logic inv);
    if (!inv) return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    else      return {1'b0, v[7:1]} ^ (v[0] ? 8'h8d : 8'h00);
  endfunction

  always @(posedge clk) begin
    if (rcon_init)        rc <= rcon_inverse ? 8'h36 : 8'h01;
    else if (rcon_update) rc <= rc_next(rc, rcon_inverse);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample cycle outputs away from the rising edge and run the monitor.
  task automatic wait_neg();
    @(negedge clk);
    cyc++;
    if (rcon_init) start_cyc = cyc;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (rcon_update) n_upd++;
    if (last_round) n_last++;
    if (rcon_mask) begin
      n_mask++;
      if (exp_q.size() == 0) check("rcon_extra_mask", 32'(exp_q.size()), 32'd1);
      else check("rcon_seq", {24'd0, rc}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    wait_neg();
    adv();
  endtask

  task automatic clear_stats();
    start_cyc = -1;
    first_ov  = -1;
    n_mask    = 0;
    n_upd     = 0;
    n_last    = 0;
    exp_q.delete();
  endtask

  task automatic start_op(input logic inv);
    clear_stats();
    for (int i = 0; i < 10; i++) exp_q.push_back(inv ? fwd_tbl[9-i] : fwd_tbl[i]);
    in_valid   = 1'b1;
    in_inverse = inv;
    wait_neg();
    check("accept_ready", in_ready, 1);
    check("accept_rcon_init", rcon_init, 1);
    check("accept_rcon_inverse", rcon_inverse, inv);
    adv();
    in_valid   = 1'b0;
    in_inverse = ~inv;
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && first_ov < 0; i++) tick();
    check("done_within_budget", first_ov >= 0, 1);
  endtask

  // Stop right after the enabled step that leaves (r,c) behind.
  task automatic step_past(input logic [3:0] r, input logic [1:0] c);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      wait_neg();
      hit = col_en && (round_idx == r) && (col_idx == c);
      adv();
    end
    check("reached_position", hit, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_strobes"}, {col_en, last_round, rcon_init, rcon_update, rcon_mask, rcon_inverse}, 0);
    check({tag, "_counters"}, {round_idx, col_idx}, 0);
  endtask

  initial begin
    fwd_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b1; rnd_valid = 1'b1;
    abort = 1'b0; out_ready = 1'b1;
    adv();
    wait_neg();
    check_all_zero("reset");
    adv();
    rst = 1'b0;
    wait_neg();
    check("release_in_ready", in_ready, 1);
    adv();

    // Forward schedule, full speed.
    start_op(1'b0);
    run_to_done(100);
    check("fwd_latency", first_ov - start_cyc, 41);
    check("fwd_mask_count", n_mask, 10);
    check("fwd_update_count", n_upd, 9);
    check("fwd_last_round_cycles", n_last, 4);
    check("fwd_queue_drained", exp_q.size(), 0);
    wait_neg();
    check("fwd_back_idle", in_ready, 1);
    adv();

    // Inverse schedule.
    start_op(1'b1);
    run_to_done(100);
    check("inv_latency", first_ov - start_cyc, 41);
    check("inv_mask_count", n_mask, 10);
    check("inv_update_count", n_upd, 9);
    check("inv_queue_drained", exp_q.size(), 0);
    tick();

    // Randomness stall for three cycles at round 2, column 1.
    start_op(1'b0);
    step_past(4'd2, 2'd0);
    rnd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_neg();
      check("stall_counters", {round_idx, col_idx}, {4'd2, 2'd1});
      check("stall_strobes", {col_en, rcon_update, rcon_mask}, 0);
      adv();
    end
    rnd_valid = 1'b1;
    run_to_done(100);
    check("stall_latency", first_ov - start_cyc, 44);
    check("stall_mask_count", n_mask, 10);
    tick();

    // Abort at round 5, column 2, then a clean restart.
    start_op(1'b0);
    step_past(4'd5, 2'd1);
    abort = 1'b1;
    wait_neg();
    check("abort_position", {round_idx, col_idx}, {4'd5, 2'd2});
    check("abort_strobes", {col_en, rcon_update, rcon_mask, last_round}, 0);
    adv();
    abort = 1'b0;
    wait_neg();
    check("abort_idle_ready", in_ready, 1);
    check("abort_counters_clear", {round_idx, col_idx}, 0);
    adv();
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_out_valid", first_ov, -1);
    start_op(1'b0);
    run_to_done(100);
    check("restart_latency", first_ov - start_cyc, 41);
    check("restart_mask_count", n_mask, 10);
    tick();

    // Back-pressure in DONE; start requests must be ignored.
    out_ready = 1'b0;
    start_op(1'b1);
    run_to_done(100);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_neg();
      check("hold_out_valid", out_valid, 1);
      check("hold_not_ready", {in_ready, rcon_init, col_en}, 0);
      adv();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_neg();
    check("handshake_out_valid", out_valid, 1);
    adv();
    wait_neg();
    check("handshake_idle", {in_ready, out_valid}, {1'b1, 1'b0});
    adv();

    // Reset pulse at round 7.
    start_op(1'b0);
    step_past(4'd6, 2'd3);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_neg();
      check_all_zero("mid_reset");
      adv();
    end
    rst = 1'b0;
    wait_neg();
    check("post_reset_ready", in_ready, 1);
    check("post_reset_counters", {round_idx, col_idx}, 0);
    adv();
    for (int i = 0; i < 3; i++) tick();
    check("post_reset_no_out_valid", first_ov, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
